instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: packs decoded fields into 32-bit words
// and streams them into instruction memory at an auto-incrementing address.
module instr_encoder (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        LoadBase,
  input  logic [31:0] BaseAddr,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  Mnemonic,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Shamt,
  input  logic [15:0] Imm,
  input  logic [25:0] Target,
  output logic        MemWrEn,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWrData,
  input  logic        MemAck,
  output logic        Illegal,
  output logic [15:0] WordCount,
  output logic        Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_wren;
  logic        r_illegal;
  logic        r_busy;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [15:0] r_wcnt;

  logic [25:0] w_rbase;
  logic [25:0] w_sbase;
  logic [25:0] w_ibase;
  logic [25:0] w_luibase;
  logic [31:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_unused_base;

  assign w_unused_base = ^BaseAddr[1:0];

  assign w_rbase   = {6'b0, Rs, Rt, Rd, 5'b0};
  assign w_sbase   = {6'b0, 5'b0, Rt, Rd, Shamt};
  assign w_ibase   = {Rs, Rt, Imm};
  assign w_luibase = {5'b0, Rt, Imm};

  always_comb begin
    w_word  = 32'h0;
    w_legal = 1'b1;
    case (Mnemonic)
      5'd0:  w_word = {w_rbase, 6'b100000};
      5'd1:  w_word = {w_rbase, 6'b100001};
      5'd2:  w_word = {w_rbase, 6'b100010};
      5'd3:  w_word = {w_rbase, 6'b100011};
      5'd4:  w_word = {w_rbase, 6'b100100};
      5'd5:  w_word = {w_rbase, 6'b100101};
      5'd6:  w_word = {w_rbase, 6'b100110};
      5'd7:  w_word = {w_rbase, 6'b100111};
      5'd8:  w_word = {w_rbase, 6'b101010};
      5'd9:  w_word = {w_rbase, 6'b101011};
      5'd10: w_word = {w_sbase, 6'b000000};
      5'd11: w_word = {w_sbase, 6'b000010};
      5'd12: w_word = {w_sbase, 6'b000011};
      5'd13: w_word = {6'b100011, w_ibase};
      5'd14: w_word = {6'b101011, w_ibase};
      5'd15: w_word = {6'b000100, w_ibase};
      5'd16: w_word = {6'b000010, Target};
      5'd17: w_word = {6'b001101, w_ibase};
      5'd18: w_word = {6'b001000, w_ibase};
      5'd19: w_word = {6'b001001, w_ibase};
      5'd20: w_word = {6'b001100, w_ibase};
      5'd21: w_word = {6'b001111, w_luibase};
      5'd22: w_word = {6'b001010, w_ibase};
      5'd23: w_word = {6'b001011, w_ibase};
      5'd24: w_word = {6'b001110, w_ibase};
      default: w_legal = 1'b0;
    endcase
  end

  assign InReady  = (r_state == S_IDLE) && !LoadBase;
  assign w_accept = InValid && InReady;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state   <= S_IDLE;
      r_wren    <= 1'b0;
      r_illegal <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= 32'h0;
      r_data    <= 32'h0;
      r_wcnt    <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (LoadBase) begin
            r_addr <= {BaseAddr[31:2], 2'b00};
          end else if (w_accept && w_legal) begin
            r_data  <= w_word;
            r_wren  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_WRITE;
          end else if (w_accept) begin
            r_illegal <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ERR;
          end
        end
        S_WRITE: begin
          if (MemAck) begin
            r_wren  <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= r_addr + 32'd4;
            r_state <= S_IDLE;
            if (r_wcnt != 16'hFFFF)
              r_wcnt <= r_wcnt + 16'd1;
          end
        end
        S_ERR: begin
          r_illegal <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_wren    <= 1'b0;
          r_illegal <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign MemWrEn   = r_wren;
  assign MemAddr   = r_addr;
  assign MemWrData = r_data;
  assign Illegal   = r_illegal;
  assign WordCount = r_wcnt;
  assign Busy      = r_busy;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, handshake, hold, wrap,
// illegal opcodes and asynchronous reset.
module tb_instr_encoder;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b1;
  logic        LoadBase = 1'b0;
  logic [31:0] BaseAddr = 32'h0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  Mnemonic = 5'd0;
  logic [4:0]  Rs = 5'd0;
  logic [4:0]  Rt = 5'd0;
  logic [4:0]  Rd = 5'd0;
  logic [4:0]  Shamt = 5'd0;
  logic [15:0] Imm = 16'h0;
  logic [25:0] Target = 26'h0;
  logic        MemWrEn;
  logic [31:0] MemAddr;
  logic [31:0] MemWrData;
  logic        MemAck = 1'b0;
  logic        Illegal;
  logic [15:0] WordCount;
  logic        Busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [15:0] exp_wc = 16'h0;

  always #5 CLK = ~CLK;

  instr_encoder dut (
    .CLK(CLK), .Reset_L(Reset_L), .LoadBase(LoadBase),
    .BaseAddr(BaseAddr), .InValid(InValid), .InReady(InReady),
    .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Shamt(Shamt), .Imm(Imm), .Target(Target),
    .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemAck(MemAck), .Illegal(Illegal), .WordCount(WordCount),
    .Busy(Busy)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Present one request, wait (bounded) for acceptance, then drop InValid.
  task automatic send(input logic [4:0] mn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt);
    int t;
    t = 0;
    while (!InReady && t < 50) begin
      tick();
      t++;
    end
    n_vec++;
    if (!InReady) begin
      n_err++;
      $display("FAIL send_ready: InReady=%b after %0d cycles, need 1", InReady, t);
    end
    Mnemonic = mn; Rs = rs; Rt = rt; Rd = rd;
    Shamt = sh; Imm = imm; Target = tgt;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  task automatic test_reset;
    #1 Reset_L = 1'b0;
    #2;
    n_vec++;
    if ({MemWrEn, Illegal, Busy} !== 3'b000 || MemAddr !== 32'h0 ||
        MemWrData !== 32'h0 || WordCount !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outs: en=%b ill=%b busy=%b addr=%h data=%h wc=%h, need all 0",
               MemWrEn, Illegal, Busy, MemAddr, MemWrData, WordCount);
    end
    tick();
    Reset_L = 1'b1;
    tick();
    n_vec++;
    if (InReady !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: InReady=%b, need 1", InReady);
    end
  endtask

  task automatic test_add;
    MemAck = 1'b1;
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    n_vec++;
    if (MemWrEn !== 1'b1 || MemWrData !== 32'h00221820 ||
        MemAddr !== 32'h0 || Busy !== 1'b1 || InReady !== 1'b0) begin
      n_err++;
      $display("FAIL add_write: en=%b data=%h addr=%h busy=%b rdy=%b, need 1 00221820 0 1 0",
               MemWrEn, MemWrData, MemAddr, Busy, InReady);
    end
    tick();
    n_vec++;
    if (MemWrEn !== 1'b0 || MemAddr !== 32'h4 || WordCount !== 16'd1) begin
      n_err++;
      $display("FAIL add_done: en=%b addr=%h wc=%0d, need 0 4 1",
               MemWrEn, MemAddr, WordCount);
    end
    exp_addr = 32'h4;
    exp_wc = 16'd1;
  endtask

  task automatic test_loadbase;
    LoadBase = 1'b1;
    BaseAddr = 32'h00400002;
    Mnemonic = 5'd0;
    InValid = 1'b1;
    #1;
    n_vec++;
    if (InReady !== 1'b0) begin
      n_err++;
      $display("FAIL lb_ready: InReady=%b, need 0", InReady);
    end
    tick();
    InValid = 1'b0;
    LoadBase = 1'b0;
    n_vec++;
    if (MemAddr !== 32'h00400000 || MemWrEn !== 1'b0) begin
      n_err++;
      $display("FAIL lb_load: addr=%h en=%b, need 00400000 0", MemAddr, MemWrEn);
    end
    send(5'd13, 5'd29, 5'd8, 5'd17, 5'd9, 16'h0004, 26'h3FFFFFF);
    n_vec++;
    if (MemWrEn !== 1'b1 || MemWrData !== 32'h8FA80004 || MemAddr !== 32'h00400000) begin
      n_err++;
      $display("FAIL lw_write: en=%b data=%h addr=%h, need 1 8FA80004 00400000",
               MemWrEn, MemWrData, MemAddr);
    end
    tick();
    send(5'd10, 5'd7, 5'd3, 5'd2, 5'd4, 16'hBEEF, 26'h1555555);
    n_vec++;
    if (MemWrEn !== 1'b1 || MemWrData !== 32'h00031100 || MemAddr !== 32'h00400004) begin
      n_err++;
      $display("FAIL sll_write: en=%b data=%h addr=%h, need 1 00031100 00400004",
               MemWrEn, MemWrData, MemAddr);
    end
    tick();
    exp_addr = 32'h00400008;
    exp_wc = 16'd3;
    n_vec++;
    if (MemAddr !== exp_addr || WordCount !== exp_wc) begin
      n_err++;
      $display("FAIL lb_after: addr=%h wc=%0d, need %h %0d",
               MemAddr, WordCount, exp_addr, exp_wc);
    end
  endtask

  task automatic test_hold;
    int highs;
    MemAck = 1'b0;
    highs = 0;
    send(5'd16, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000100);
    Mnemonic = 5'd0;
    Rs = 5'd5;
    for (int i = 0; i < 6; i++) begin
      if (MemWrEn === 1'b1) highs++;
      n_vec++;
      if (MemWrData !== 32'h08000100 || MemAddr !== exp_addr || InReady !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: data=%h addr=%h rdy=%b, need 08000100 %h 0",
                 i, MemWrData, MemAddr, InReady, exp_addr);
      end
      LoadBase = (i == 2);
      BaseAddr = 32'h12345678;
      if (i == 5) MemAck = 1'b1;
      tick();
    end
    LoadBase = 1'b0;
    exp_addr = exp_addr + 32'd4;
    exp_wc = exp_wc + 16'd1;
    n_vec++;
    if (highs != 6 || MemWrEn !== 1'b0 || MemAddr !== exp_addr || WordCount !== exp_wc) begin
      n_err++;
      $display("FAIL hold_done: highs=%0d en=%b addr=%h wc=%0d, need 6 0 %h %0d",
               highs, MemWrEn, MemAddr, WordCount, exp_addr, exp_wc);
    end
  endtask

  task automatic test_lui_illegal;
    MemAck = 1'b1;
    send(5'd21, 5'd5, 5'd1, 5'd9, 5'd9, 16'h1234, 26'h0);
    n_vec++;
    if (MemWrEn !== 1'b1 || MemWrData !== 32'h3C011234) begin
      n_err++;
      $display("FAIL lui_write: en=%b data=%h, need 1 3C011234", MemWrEn, MemWrData);
    end
    tick();
    exp_addr = exp_addr + 32'd4;
    exp_wc = exp_wc + 16'd1;
    send(5'd27, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    n_vec++;
    if (Illegal !== 1'b1 || MemWrEn !== 1'b0 || Busy !== 1'b1 || InReady !== 1'b0) begin
      n_err++;
      $display("FAIL ill_pulse: ill=%b en=%b busy=%b rdy=%b, need 1 0 1 0",
               Illegal, MemWrEn, Busy, InReady);
    end
    tick();
    n_vec++;
    if (Illegal !== 1'b0 || MemWrEn !== 1'b0 || Busy !== 1'b0 ||
        WordCount !== exp_wc || MemAddr !== exp_addr) begin
      n_err++;
      $display("FAIL ill_after: ill=%b en=%b busy=%b wc=%0d addr=%h, need 0 0 0 %0d %h",
               Illegal, MemWrEn, Busy, WordCount, MemAddr, exp_wc, exp_addr);
    end
  endtask

  task automatic test_encodings;
    logic [4:0]  mn [8];
    logic [4:0]  rs [8];
    logic [4:0]  rt [8];
    logic [4:0]  rd [8];
    logic [4:0]  sh [8];
    logic [15:0] im [8];
    logic [25:0] tg [8];
    logic [31:0] ex [8];
    mn = '{5'd2, 5'd7, 5'd12, 5'd17, 5'd15, 5'd23, 5'd9, 5'd16};
    rs = '{5'd4, 5'd31, 5'd9, 5'd2, 5'd1, 5'd7, 5'd1, 5'd31};
    rt = '{5'd5, 5'd31, 5'd10, 5'd3, 5'd0, 5'd8, 5'd2, 5'd31};
    rd = '{5'd6, 5'd31, 5'd11, 5'd31, 5'd31, 5'd31, 5'd3, 5'd31};
    sh = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0, 5'd31};
    im = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0010, 16'hFFFF, 16'hFFFF};
    tg = '{26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF,
           26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF};
    ex = '{32'h00853022, 32'h03FFF827, 32'h000A5FC3, 32'h3443FFFF,
           32'h10208000, 32'h2CE80010, 32'h0022182B, 32'h0BFFFFFF};
    MemAck = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(mn[i], rs[i], rt[i], rd[i], sh[i], im[i], tg[i]);
      n_vec++;
      if (MemWrEn !== 1'b1 || MemWrData !== ex[i]) begin
        n_err++;
        $display("FAIL enc_mn%0d: en=%b data=%h, need 1 %h", mn[i], MemWrEn, MemWrData, ex[i]);
      end
      tick();
      exp_wc = exp_wc + 16'd1;
    end
  endtask

  task automatic test_back_to_back;
    LoadBase = 1'b1;
    BaseAddr = 32'hFFFFFFFC;
    tick();
    LoadBase = 1'b0;
    MemAck = 1'b1;
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    n_vec++;
    if (MemWrEn !== 1'b1 || MemAddr !== 32'hFFFFFFFC) begin
      n_err++;
      $display("FAIL b2b_first: en=%b addr=%h, need 1 FFFFFFFC", MemWrEn, MemAddr);
    end
    tick();
    n_vec++;
    if (InReady !== 1'b1 || MemAddr !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_wrap: rdy=%b addr=%h, need 1 00000000", InReady, MemAddr);
    end
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    n_vec++;
    if (MemWrEn !== 1'b1 || MemAddr !== 32'h0 || MemWrData !== 32'h00221820) begin
      n_err++;
      $display("FAIL b2b_second: en=%b addr=%h data=%h, need 1 00000000 00221820",
               MemWrEn, MemAddr, MemWrData);
    end
    tick();
    exp_wc = exp_wc + 16'd2;
    n_vec++;
    if (MemAddr !== 32'h4 || WordCount !== exp_wc) begin
      n_err++;
      $display("FAIL b2b_count: addr=%h wc=%0d, need 00000004 %0d", MemAddr, WordCount, exp_wc);
    end
  endtask

  task automatic test_reset_mid_write;
    MemAck = 1'b0;
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    #2 Reset_L = 1'b0;
    #1;
    n_vec++;
    if ({MemWrEn, Illegal, Busy} !== 3'b000 || MemAddr !== 32'h0 ||
        MemWrData !== 32'h0 || WordCount !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid: en=%b ill=%b busy=%b addr=%h data=%h wc=%h, need all 0",
               MemWrEn, Illegal, Busy, MemAddr, MemWrData, WordCount);
    end
    MemAck = 1'b1;
    tick();
    Reset_L = 1'b1;
    tick();
    n_vec++;
    if (InReady !== 1'b1 || WordCount !== 16'h0 || MemWrEn !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: rdy=%b wc=%0d en=%b, need 1 0 0", InReady, WordCount, MemWrEn);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_loadbase();
    test_hold();
    test_lui_illegal();
    test_encodings();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
